inc_pulse_gen: RTL and testbench

- Programmable two-channel stimulus generator that drives the INCA/INCB increment requests of the increment/compare datapath (8-bit result C).
- Replaces hand-timed testbench delays with cycle-exact, configurable windows.
- Lets SAIF/power runs sweep activity profiles from a register-style config port.
- Sits between the config/control interface and the increment/compare block inputs.

---
 rtl/inc_pulse_gen.sv | 195 +++++++++++++++++++
 tb/tb_inc_pulse_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_pulse_gen.sv
// Two-channel programmable pulse generator driving the INCA/INCB increment requests.
// Window positions and lengths are latched at launch; every output is registered.
module inc_pulse_gen #(
    parameter int W       = 8,
    parameter bit LOOP_EN = 1'b0
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    // "repeat" is a reserved word in SystemVerilog, so the loop request is named rpt
    input  logic         rpt,
    input  logic [W-1:0] a_start,
    input  logic [W-1:0] a_len,
    input  logic [W-1:0] b_start,
    input  logic [W-1:0] b_len,
    output logic         INCA,
    output logic         INCB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] cnt_a,
    output logic [W-1:0] cnt_b
);

    // state  | meaning
    // S_IDLE | after reset or abort, waiting for start
    // S_RUN  | sequence in progress, t advancing
    // S_DONE | sequence finished, counts held, waiting for start
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0] a_start_q;
    logic [W-1:0] a_len_q;
    logic [W-1:0] b_start_q;
    logic [W-1:0] b_len_q;

    logic [W:0]   t;
    logic [W:0]   t_nx;
    logic [W:0]   a_end;
    logic [W:0]   b_end;
    logic [W:0]   t_end;
    logic [W:0]   t_last;

    logic         a_en;
    logic         b_en;
    logic         win_a;
    logic         win_b;
    logic         end_hit;
    logic         loop_ok;

    logic         inca_nx;
    logic         incb_nx;
    logic         busy_nx;
    logic         done_nx;
    logic [W-1:0] cnt_a_nx;
    logic [W-1:0] cnt_b_nx;
    logic [W-1:0] cnt_a_base;
    logic [W-1:0] cnt_b_base;
    logic         cfg_load;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] base, input logic inc);
        logic [W-1:0] res;
        res = base;
        if (inc && (base != '1)) begin
            res = base + W'(1);
        end
        return res;
    endfunction

    // A disabled channel does not stretch the sequence, so both lengths 0 gives t_end 0.
    assign a_en  = (a_len_q != '0);
    assign b_en  = (b_len_q != '0);
    assign a_end = a_en ? ({1'b0, a_start_q} + {1'b0, a_len_q}) : '0;
    assign b_end = b_en ? ({1'b0, b_start_q} + {1'b0, b_len_q}) : '0;
    assign t_end = (a_end > b_end) ? a_end : b_end;

    // t_end of 0 still needs one done cycle, so it ends at t=0 like t_end of 1.
    assign t_last = (t_end == '0) ? '0 : (t_end - (W+1)'(1));

    assign win_a   = a_en && ({1'b0, a_start_q} <= t) && (t < a_end);
    assign win_b   = b_en && ({1'b0, b_start_q} <= t) && (t < b_end);
    assign end_hit = (state == S_RUN) && (t == t_last);
    assign loop_ok = LOOP_EN && rpt;

    assign cnt_a_base = (t == '0) ? '0 : cnt_a;
    assign cnt_b_base = (t == '0) ? '0 : cnt_b;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (end_hit && !loop_ok) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_nx = S_RUN;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and the sequence datapath.
    always_comb begin
        inca_nx  = 1'b0;
        incb_nx  = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        cnt_a_nx = cnt_a;
        cnt_b_nx = cnt_b;
        t_nx     = t;
        cfg_load = 1'b0;
        if (!abort) begin
            case (state)
                S_RUN: begin
                    inca_nx  = win_a;
                    incb_nx  = win_b;
                    busy_nx  = 1'b1;
                    done_nx  = end_hit;
                    cnt_a_nx = sat_inc(cnt_a_base, win_a);
                    cnt_b_nx = sat_inc(cnt_b_base, win_b);
                    if (end_hit && loop_ok) begin
                        t_nx = '0;
                    end else begin
                        t_nx = t + (W+1)'(1);
                    end
                end
                default: begin
                    if (start) begin
                        cfg_load = 1'b1;
                        t_nx     = '0;
                        cnt_a_nx = '0;
                        cnt_b_nx = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            t         <= '0;
            INCA      <= 1'b0;
            INCB      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            a_start_q <= '0;
            a_len_q   <= '0;
            b_start_q <= '0;
            b_len_q   <= '0;
        end else begin
            t     <= t_nx;
            INCA  <= inca_nx;
            INCB  <= incb_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            cnt_a <= cnt_a_nx;
            cnt_b <= cnt_b_nx;
            if (cfg_load) begin
                a_start_q <= a_start;
                a_len_q   <= a_len;
                b_start_q <= b_start;
                b_len_q   <= b_len;
            end
        end
    end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Directed bench for inc_pulse_gen: one looping instance and one single-shot instance
// share the same stimulus; expectations are hand-derived cycle tables.
module tb_inc_pulse_gen;

    logic       ck;
    logic       rst;
    logic       start;
    logic       abort;
    logic       rpt;
    logic [7:0] a_start;
    logic [7:0] a_len;
    logic [7:0] b_start;
    logic [7:0] b_len;

    logic       inca, incb, busy, done;
    logic [7:0] cnt_a, cnt_b;
    logic       inca1, incb1, busy1, done1;
    logic [7:0] cnt_a1, cnt_b1;

    int n_tests;
    int n_fail;

    inc_pulse_gen #(.W(8), .LOOP_EN(1'b1)) u_dut (
        .ck(ck), .rst(rst), .start(start), .abort(abort), .rpt(rpt),
        .a_start(a_start), .a_len(a_len), .b_start(b_start), .b_len(b_len),
        .INCA(inca), .INCB(incb), .busy(busy), .done(done),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    inc_pulse_gen #(.W(8), .LOOP_EN(1'b0)) u_dut1 (
        .ck(ck), .rst(rst), .start(start), .abort(abort), .rpt(rpt),
        .a_start(a_start), .a_len(a_len), .b_start(b_start), .b_len(b_len),
        .INCA(inca1), .INCB(incb1), .busy(busy1), .done(done1),
        .cnt_a(cnt_a1), .cnt_b(cnt_b1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // After launch returns, the start edge has passed; the next step shows cycle 0.
    task automatic launch(input logic [7:0] as, input logic [7:0] al,
                          input logic [7:0] bs, input logic [7:0] bl);
        a_start = as;
        a_len   = al;
        b_start = bs;
        b_len   = bl;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b0;
        repeat (2) @(posedge ck);
        #1;
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b cnt_a=%0d cnt_b=%0d exp=0000 0 0", got, cnt_a, cnt_b);
        end
        rst = 1'b1;
        launch(8'd0, 8'd5, 8'd0, 8'd0);
        repeat (3) step();
        n_tests++;
        if (inca !== 1'b1 || cnt_a !== 8'd3) begin
            n_fail++;
            $display("FAIL reset_pre inca=%b cnt_a=%0d exp 1 3", inca, cnt_a);
        end
        #2 rst = 1'b0;
        #1;
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000 || cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async got=%b cnt_a=%0d exp=0000 0", got, cnt_a);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || inca !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b inca=%b exp 0 0", busy, inca);
        end
    endtask

    task automatic test_reference();
        logic [3:0] got, exp;
        launch(8'd1, 8'd8, 8'd4, 8'd10);
        for (int c = 0; c < 16; c++) begin
            step();
            exp = {(c >= 1 && c <= 8), (c >= 4 && c <= 13), (c == 13), (c <= 13)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ref_cyc%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 13 || c == 15) begin
                n_tests++;
                if (cnt_a !== 8'd8 || cnt_b !== 8'd10) begin
                    n_fail++;
                    $display("FAIL ref_cnt_cyc%0d cnt_a=%0d cnt_b=%0d exp 8 10", c, cnt_a, cnt_b);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        logic [3:0] got, exp;
        launch(8'd0, 8'd0, 8'd0, 8'd3);
        for (int c = 0; c < 5; c++) begin
            step();
            exp = {1'b0, (c <= 2), (c == 2), (c <= 2)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL zlen_cyc%0d got=%b exp=%b", c, got, exp);
            end
        end
        n_tests++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd3) begin
            n_fail++;
            $display("FAIL zlen_cnt cnt_a=%0d cnt_b=%0d exp 0 3", cnt_a, cnt_b);
        end
        launch(8'd0, 8'd0, 8'd0, 8'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            exp = {1'b0, 1'b0, (c == 0), (c == 0)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL both_zero_cyc%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_max_width();
        logic [3:0] got, exp;
        launch(8'd255, 8'd255, 8'd0, 8'd0);
        for (int c = 0; c < 512; c++) begin
            step();
            exp = {(c >= 255 && c <= 509), 1'b0, (c == 509), (c <= 509)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL max_cyc%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 509 || c == 511) begin
                n_tests++;
                if (cnt_a !== 8'd255) begin
                    n_fail++;
                    $display("FAIL max_cnt_cyc%0d cnt_a=%0d exp 255", c, cnt_a);
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        logic [3:0] got, exp;
        launch(8'd3, 8'd2, 8'd0, 8'd0);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                start   = 1'b1;
                a_start = 8'd0;
                a_len   = 8'd9;
            end
            step();
            start = 1'b0;
            exp = {(c >= 3 && c <= 4), 1'b0, (c == 4), (c <= 4)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL start_in_run_cyc%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] got;
        launch(8'd0, 8'd3, 8'd0, 8'd0);
        repeat (3) step();
        n_tests++;
        if (done !== 1'b1 || inca !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_done done=%b inca=%b exp 1 1", done, inca);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000 || cnt_a !== 8'd3) begin
            n_fail++;
            $display("FAIL abort_vs_start got=%b cnt_a=%0d exp=0000 3", got, cnt_a);
        end
        abort = 1'b0;
        start = 1'b0;
        step();
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_no_restart got=%b exp=0000", got);
        end
        launch(8'd0, 8'd3, 8'd0, 8'd0);
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000 || cnt_a !== 8'd2) begin
            n_fail++;
            $display("FAIL abort_vs_end got=%b cnt_a=%0d exp=0000 2", got, cnt_a);
        end
        step();
        got = {inca, incb, done, busy};
        n_tests++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle got=%b exp=0000", got);
        end
    endtask

    task automatic test_repeat();
        logic [3:0] got, exp;
        rpt = 1'b1;
        launch(8'd0, 8'd2, 8'd0, 8'd0);
        for (int c = 0; c < 7; c++) begin
            if (c == 5) rpt = 1'b0;
            step();
            exp = {(c <= 5), 1'b0, (c <= 5) && (c % 2 == 1), (c <= 5)};
            got = {inca, incb, done, busy};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL repeat_cyc%0d got=%b exp=%b", c, got, exp);
            end
            exp = {(c <= 1), 1'b0, (c == 1), (c <= 1)};
            got = {inca1, incb1, done1, busy1};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL single_shot_cyc%0d got=%b exp=%b", c, got, exp);
            end
            if (c == 4 || c == 5) begin
                n_tests++;
                if (cnt_a !== 8'(c - 3)) begin
                    n_fail++;
                    $display("FAIL repeat_cnt_cyc%0d cnt_a=%0d exp %0d", c, cnt_a, c - 3);
                end
            end
        end
        n_tests++;
        if (cnt_a !== 8'd2 || cnt_a1 !== 8'd2) begin
            n_fail++;
            $display("FAIL repeat_cnt_hold cnt_a=%0d cnt_a1=%0d exp 2 2", cnt_a, cnt_a1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        rpt     = 1'b0;
        a_start = 8'd0;
        a_len   = 8'd0;
        b_start = 8'd0;
        b_len   = 8'd0;
        test_reset();
        test_reference();
        test_zero_len();
        test_max_width();
        test_start_in_run();
        test_abort();
        test_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
